io_l2_rr_arbiter: RTL and testbench

IO_L2_RR_ARBITER -- requirements
Module: io_l2_rr_arbiter

---
 rtl/io_l2_rr_arbiter_if.sv | 54 +++++
 rtl/io_l2_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_io_l2_rr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/io_l2_rr_arbiter_if.sv
// rtl/io_l2_rr_arbiter_if.sv - channel and L2 port bundle for io_l2_rr_arbiter
// Optional IO_L2_ARB_PRIO_EN adds the per-channel priority input ch_prio_i.
interface io_l2_rr_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [N_CH-1:0]        ch_req_i;
    logic [N_CH-1:0]        ch_we_i;
    logic [N_CH*ADDR_W-1:0] ch_addr_i;
    logic [N_CH*DATA_W-1:0] ch_wdata_i;
    logic [N_CH*BE_W-1:0]   ch_be_i;
`ifdef IO_L2_ARB_PRIO_EN
    logic [N_CH-1:0]        ch_prio_i;
`endif
    logic [N_CH-1:0]        ch_gnt_o;
    logic [N_CH-1:0]        ch_rvalid_o;
    logic [DATA_W-1:0]      ch_rdata_o;

    logic                   l2_req_o;
    logic                   l2_we_o;
    logic [ADDR_W-1:0]      l2_addr_o;
    logic [DATA_W-1:0]      l2_wdata_o;
    logic [BE_W-1:0]        l2_be_o;
    logic                   l2_gnt_i;
    logic                   l2_rvalid_i;
    logic [DATA_W-1:0]      l2_rdata_i;

    logic                   err_o;

    modport master (
`ifdef IO_L2_ARB_PRIO_EN
        input  ch_prio_i,
`endif
        input  ch_req_i, ch_we_i, ch_addr_i, ch_wdata_i, ch_be_i,
        output ch_gnt_o, ch_rvalid_o, ch_rdata_o,
        output l2_req_o, l2_we_o, l2_addr_o, l2_wdata_o, l2_be_o,
        input  l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        output err_o
    );

    modport slave (
`ifdef IO_L2_ARB_PRIO_EN
        output ch_prio_i,
`endif
        output ch_req_i, ch_we_i, ch_addr_i, ch_wdata_i, ch_be_i,
        input  ch_gnt_o, ch_rvalid_o, ch_rdata_o,
        input  l2_req_o, l2_we_o, l2_addr_o, l2_wdata_o, l2_be_o,
        output l2_gnt_i, l2_rvalid_i, l2_rdata_i,
        input  err_o
    );
endinterface

// File: rtl/io_l2_rr_arbiter.sv
// rtl/io_l2_rr_arbiter.sv - round-robin N-channel arbiter onto one L2 port with in-order response routing
// Optional IO_L2_ARB_PRIO_EN: priority-flagged channels win over the rest in IDLE.
module io_l2_rr_arbiter #(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    io_l2_rr_arbiter_if.master  bus
);
    localparam int BE_W    = DATA_W / 8;
    localparam int ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FIFO_AW = $clog2(MAX_OUTST);
    localparam int CNT_W   = FIFO_AW + 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_lock_ch;
    logic [ID_W-1:0]     w_lock_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_fifo [MAX_OUTST];
    logic [FIFO_AW-1:0]  r_wptr;
    logic [FIFO_AW-1:0]  r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err;

    logic [ID_W-1:0]     w_rr_sel;
    logic [ID_W-1:0]     w_sel;
    logic                w_full;
    logic                w_empty;
    logic                w_l2_req;
    logic                w_push;
    logic                w_pop;
    logic                w_stray;

    // First set bit of req at or after ptr, wrapping; returns ptr when none set.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

`ifdef IO_L2_ARB_PRIO_EN
    logic [N_CH-1:0] w_prio_req;
    assign w_prio_req = bus.ch_req_i & bus.ch_prio_i;
    assign w_rr_sel   = (|w_prio_req) ? rr_pick(w_prio_req, r_rr_ptr)
                                      : rr_pick(bus.ch_req_i, r_rr_ptr);
`else
    assign w_rr_sel   = rr_pick(bus.ch_req_i, r_rr_ptr);
`endif

    // Reset pins the L2 bundle to channel 0 regardless of who is requesting.
    assign w_sel    = !rst_ni ? '0 : ((r_state == ST_LOCKED) ? r_lock_ch : w_rr_sel);
    assign w_full   = (r_count == CNT_W'(MAX_OUTST));
    assign w_empty  = (r_count == '0);
    assign w_l2_req = rst_ni & bus.ch_req_i[w_sel] & ~w_full;
    assign w_push   = w_l2_req & bus.l2_gnt_i;
    assign w_pop    = rst_ni & bus.l2_rvalid_i & ~w_empty;
    assign w_stray  = rst_ni & bus.l2_rvalid_i & w_empty;

    assign bus.l2_req_o    = w_l2_req;
    assign bus.l2_we_o     = bus.ch_we_i[w_sel];
    assign bus.l2_addr_o   = bus.ch_addr_i[w_sel*ADDR_W +: ADDR_W];
    assign bus.l2_wdata_o  = bus.ch_wdata_i[w_sel*DATA_W +: DATA_W];
    assign bus.l2_be_o     = bus.ch_be_i[w_sel*BE_W +: BE_W];
    assign bus.ch_gnt_o    = w_push ? (N_CH'(1) << w_sel) : '0;
    assign bus.ch_rvalid_o = w_pop ? (N_CH'(1) << r_fifo[r_rptr]) : '0;
    assign bus.ch_rdata_o  = w_pop ? bus.l2_rdata_i : '0;
    assign bus.err_o       = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_ch;
        case (r_state)
            ST_IDLE: begin
                if (w_l2_req && !bus.l2_gnt_i) begin
                    w_state_nxt = ST_LOCKED;
                    w_lock_nxt  = w_sel;
                end
            end
            ST_LOCKED: begin
                if (bus.l2_gnt_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= (w_sel == ID_W'(N_CH - 1)) ? '0 : w_sel + ID_W'(1);
                r_wptr   <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_stray) r_err <= 1'b1;
        end
    end

    // ID storage needs no reset: occupancy and pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr] <= w_sel;
    end
endmodule

// File: tb/tb_io_l2_rr_arbiter.sv
// tb/tb_io_l2_rr_arbiter.sv - directed vector bench for io_l2_rr_arbiter
module tb_io_l2_rr_arbiter;
    localparam int N_CH   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    io_l2_rr_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    io_l2_rr_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [3:0]  e_gnt;
        logic [3:0]  e_rv;
        logic [31:0] e_rdata;
        int          e_sel;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [31:0] addr_of(input int ch);
        return 32'h1000_0000 + 32'(ch) * 32'h100;
    endfunction
    function automatic logic [31:0] wdata_of(input int ch);
        return 32'hD000_0000 | 32'(ch);
    endfunction
    function automatic logic be_we_of(input int ch);
        return ch[0];
    endfunction
    function automatic logic [3:0] be_of(input int ch);
        return 4'b0001 << ch;
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic e_req, input logic [3:0] e_gnt,
                                input logic [3:0] e_rv, input logic [31:0] e_rdata, input int e_sel);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_sel = e_sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input int ch);
        chk({tag, " l2_addr"},  64'(bus.l2_addr_o),  64'(addr_of(ch)));
        chk({tag, " l2_wdata"}, 64'(bus.l2_wdata_o), 64'(wdata_of(ch)));
        chk({tag, " l2_we"},    64'(bus.l2_we_o),    64'(be_we_of(ch)));
        chk({tag, " l2_be"},    64'(bus.l2_be_o),    64'(be_of(ch)));
    endtask

    task automatic drive(input logic [3:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
        bus.ch_req_i    = req;
        bus.l2_gnt_i    = gnt;
        bus.l2_rvalid_i = rv;
        bus.l2_rdata_i  = rdata;
    endtask

    initial begin
        for (int ch = 0; ch < N_CH; ch++) begin
            bus.ch_addr_i[ch*ADDR_W +: ADDR_W]  = addr_of(ch);
            bus.ch_wdata_i[ch*DATA_W +: DATA_W] = wdata_of(ch);
            bus.ch_we_i[ch]                     = be_we_of(ch);
            bus.ch_be_i[ch*BE_W +: BE_W]        = be_of(ch);
        end
`ifdef IO_L2_ARB_PRIO_EN
        bus.ch_prio_i = '0;
`endif
        // All requesting with l2 always granting: grants 0,1,2,3,0 with responses trailing one cycle.
        tbl[0]  = mk(4'b1111, 1, 0, 32'h0,        1, 4'b0001, 4'b0000, 32'h0,        0);
        tbl[1]  = mk(4'b1111, 1, 1, 32'h11111111, 1, 4'b0010, 4'b0001, 32'h11111111, 1);
        tbl[2]  = mk(4'b1111, 1, 1, 32'h22222222, 1, 4'b0100, 4'b0010, 32'h22222222, 2);
        tbl[3]  = mk(4'b1111, 1, 1, 32'h33333333, 1, 4'b1000, 4'b0100, 32'h33333333, 3);
        tbl[4]  = mk(4'b1111, 1, 1, 32'h44444444, 1, 4'b0001, 4'b1000, 32'h44444444, 0);
        tbl[5]  = mk(4'b0100, 1, 1, 32'h55555555, 1, 4'b0100, 4'b0001, 32'h55555555, 2);
        // rr_ptr=3: ch1 locks, ch0 joins but must not steal the port until ch1 is granted.
        tbl[6]  = mk(4'b0010, 0, 0, 32'h0,        1, 4'b0000, 4'b0000, 32'h0,        1);
        tbl[7]  = mk(4'b0011, 0, 0, 32'h0,        1, 4'b0000, 4'b0000, 32'h0,        1);
        tbl[8]  = mk(4'b0011, 0, 0, 32'h0,        1, 4'b0000, 4'b0000, 32'h0,        1);
        tbl[9]  = mk(4'b0011, 1, 0, 32'h0,        1, 4'b0010, 4'b0000, 32'h0,        1);
        tbl[10] = mk(4'b0000, 0, 1, 32'h66666666, 0, 4'b0000, 4'b0100, 32'h66666666, -1);
        tbl[11] = mk(4'b0000, 0, 1, 32'h77777777, 0, 4'b0000, 4'b0010, 32'h77777777, -1);
        // ch2 then ch0, responses routed in grant order.
        tbl[12] = mk(4'b0100, 1, 0, 32'h0,        1, 4'b0100, 4'b0000, 32'h0,        2);
        tbl[13] = mk(4'b0001, 1, 0, 32'h0,        1, 4'b0001, 4'b0000, 32'h0,        0);
        tbl[14] = mk(4'b0000, 0, 1, 32'hA5A5A5A5, 0, 4'b0000, 4'b0100, 32'hA5A5A5A5, -1);
        tbl[15] = mk(4'b0000, 0, 1, 32'h5A5A5A5A, 0, 4'b0000, 4'b0001, 32'h5A5A5A5A, -1);
        // Fill the ID FIFO, then stall until a response frees a slot (not in the pop cycle itself).
        tbl[16] = mk(4'b1111, 1, 0, 32'h0,        1, 4'b0010, 4'b0000, 32'h0,        1);
        tbl[17] = mk(4'b1111, 1, 0, 32'h0,        1, 4'b0100, 4'b0000, 32'h0,        2);
        tbl[18] = mk(4'b1111, 1, 0, 32'h0,        1, 4'b1000, 4'b0000, 32'h0,        3);
        tbl[19] = mk(4'b1111, 1, 0, 32'h0,        1, 4'b0001, 4'b0000, 32'h0,        0);
        tbl[20] = mk(4'b1111, 1, 0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        1);
        tbl[21] = mk(4'b1111, 1, 0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        1);
        tbl[22] = mk(4'b1111, 1, 1, 32'hCAFEF00D, 0, 4'b0000, 4'b0010, 32'hCAFEF00D, 1);
        tbl[23] = mk(4'b1111, 1, 0, 32'h0,        1, 4'b0010, 4'b0000, 32'h0,        1);

        // Reset with activity on the inputs: everything quiet, bundle shows channel 0.
        drive(4'b0100, 1, 1, 32'h12345678);
        #2;
        chk("rst l2_req",    64'(bus.l2_req_o),    64'h0);
        chk("rst ch_gnt",    64'(bus.ch_gnt_o),    64'h0);
        chk("rst ch_rvalid", 64'(bus.ch_rvalid_o), 64'h0);
        chk("rst ch_rdata",  64'(bus.ch_rdata_o),  64'h0);
        chk("rst err",       64'(bus.err_o),       64'h0);
        chk_bundle("rst", 0);
        @(negedge clk);
        drive(4'b0000, 0, 0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            string tag;
            @(negedge clk);
            drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, " l2_req"},    64'(bus.l2_req_o),    64'(tbl[i].e_req));
            chk({tag, " ch_gnt"},    64'(bus.ch_gnt_o),    64'(tbl[i].e_gnt));
            chk({tag, " ch_rvalid"}, 64'(bus.ch_rvalid_o), 64'(tbl[i].e_rv));
            if (tbl[i].e_rv != 4'b0000)
                chk({tag, " ch_rdata"}, 64'(bus.ch_rdata_o), 64'(tbl[i].e_rdata));
            chk({tag, " err"},       64'(bus.err_o),       64'h0);
            if (tbl[i].e_sel >= 0) chk_bundle(tag, tbl[i].e_sel);
        end

        // Mid-operation reset with four IDs outstanding; they must be discarded.
        @(negedge clk);
        drive(4'b0100, 1, 1, 32'hBBBBBBBB);
        rst_n = 1'b0;
        #1;
        chk("midrst l2_req",    64'(bus.l2_req_o),    64'h0);
        chk("midrst ch_gnt",    64'(bus.ch_gnt_o),    64'h0);
        chk("midrst ch_rvalid", 64'(bus.ch_rvalid_o), 64'h0);
        chk("midrst err",       64'(bus.err_o),       64'h0);
        chk_bundle("midrst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 0, 1, 32'hDEADBEEF);
        #1;
        chk("stray ch_rvalid", 64'(bus.ch_rvalid_o), 64'h0);
        @(negedge clk);
        drive(4'b0000, 0, 0, 32'h0);
        #1;
        chk("stray err set", 64'(bus.err_o), 64'h1);
        @(negedge clk);
        drive(4'b0001, 1, 0, 32'h0);
        #1;
        chk("post-rst gnt", 64'(bus.ch_gnt_o), 64'h1);
        chk("err sticky 1", 64'(bus.err_o),    64'h1);
        @(negedge clk);
        drive(4'b0000, 0, 1, 32'h0F0F0F0F);
        #1;
        chk("post-rst rvalid", 64'(bus.ch_rvalid_o), 64'h1);
        @(negedge clk);
        drive(4'b0000, 0, 0, 32'h0);
        #1;
        chk("err sticky 2", 64'(bus.err_o), 64'h1);

`ifdef IO_L2_ARB_PRIO_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ch_prio_i = 4'b1000;
        drive(4'b1001, 1, 0, 32'h0);
        #1;
        chk("prio gnt ch3", 64'(bus.ch_gnt_o), 64'h8);
        chk_bundle("prio", 3);
        @(negedge clk);
        bus.ch_prio_i = 4'b0000;
        drive(4'b0000, 0, 0, 32'h0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
